// File: rtl/hack_mem_bus_if.sv
// CPU-side data bus of the Hack memory stage.
// The CPU core drives the master modport and the memory stage implements the slave modport.
interface hack_mem_bus_if;
   logic [15:0] cpu_address;   // A register
   logic        cpu_load;      // single-cycle write strobe
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_busy;      // screen region owned or claimed by video

   modport master (
      output cpu_address,
      output cpu_load,
      output cpu_wdata,
      input  cpu_rdata,
      input  cpu_busy
   );

   modport slave (
      input  cpu_address,
      input  cpu_load,
      input  cpu_wdata,
      output cpu_rdata,
      output cpu_busy
   );
endinterface

// File: rtl/hack_mem_bus.sv
// Hack memory bus stage.
// It decodes the CPU data address into the RAM, screen, keyboard and unmapped regions.
// It shares the screen RAM port between the CPU and the video scan-out reader.
// It returns CPU read data one cycle after a stable address.
//
// Optional build macro HACK_MEM_BUS_ERR_EN:
//   - Defined: bus_err is a sticky flag. It sets after any CPU write to the keyboard or to an
//     unmapped address.
//   - Undefined: bus_err is tied low and no error logic exists.
module hack_mem_bus #(
   parameter int          CPU_WINDOW = 4,        // guaranteed CPU screen cycles after each video word (1..15)
   parameter logic [15:0] KBD_ADDR   = 16'h6000
) (
   input  logic              clk,
   input  logic              reset,
   hack_mem_bus_if.slave     cpu,
   output logic [13:0]       ram_addr,
   output logic              ram_we,
   output logic [15:0]       ram_wdata,
   input  logic [15:0]       ram_rdata,
   output logic [12:0]       scr_addr,
   output logic              scr_we,
   output logic [15:0]       scr_wdata,
   input  logic [15:0]       scr_rdata,
   input  logic              vid_req,
   input  logic [12:0]       vid_addr,
   output logic              vid_ack,
   output logic [15:0]       vid_data,
   input  logic [15:0]       kbd_code,
   output logic              bus_err
);

   typedef enum logic [1:0] {
      SEL_RAM  = 2'd0,
      SEL_SCR  = 2'd1,
      SEL_KBD  = 2'd2,
      SEL_NONE = 2'd3
   } sel_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_VID_RD  = 2'd1,
      ST_VID_ACK = 2'd2,
      ST_CPU_WIN = 2'd3
   } state_t;

   localparam logic [3:0] WIN_LOAD = 4'(CPU_WINDOW - 1);

   state_t      state;
   sel_t        region;
   sel_t        rd_sel;
   logic [3:0]  win_cnt;
   logic        vid_ack_reg;
   logic [15:0] vid_data_reg;
   logic [15:0] kbd_meta;
   logic [15:0] kbd_sync;

   // Region decode. RAM has first priority, then the screen, then the single keyboard word.
   always_comb begin
      region = SEL_NONE;
      if (!cpu.cpu_address[14])
         region = SEL_RAM;
      else if (cpu.cpu_address[14:13] == 2'b10)
         region = SEL_SCR;
      else if (cpu.cpu_address == KBD_ADDR)
         region = SEL_KBD;
   end

   // The RAM path goes straight through from the CPU. Video never touches RAM, so it never stalls.
   assign ram_addr  = cpu.cpu_address[13:0];
   assign ram_wdata = cpu.cpu_wdata;
   assign ram_we    = cpu.cpu_load && (region == SEL_RAM);

   // cpu_busy is asserted in any region.
   // In IDLE a pending video request already claims the screen, so the video wins a same-cycle tie.
   always_comb begin
      cpu.cpu_busy = 1'b0;
      case (state)
         ST_IDLE:    cpu.cpu_busy = vid_req;
         ST_VID_RD:  cpu.cpu_busy = 1'b1;
         ST_VID_ACK: cpu.cpu_busy = 1'b1;
         default:    cpu.cpu_busy = 1'b0;
      endcase
   end

   // Screen port. Video drives the address only during its read cycle.
   // CPU writes made while busy are dropped.
   assign scr_wdata = cpu.cpu_wdata;
   assign scr_addr  = (state == ST_VID_RD) ? vid_addr : cpu.cpu_address[12:0];
   assign scr_we    = cpu.cpu_load && (region == SEL_SCR) && !cpu.cpu_busy;

   // The region is registered so that it lines up with the one-cycle latency of the block RAMs.
   always_ff @(posedge clk) begin
      if (reset)
         rd_sel <= SEL_NONE;
      else
         rd_sel <= region;
   end

   // The CPU read data mux selects with the registered region. Unmapped reads return zero.
   always_comb begin
      cpu.cpu_rdata = 16'h0000;
      case (rd_sel)
         SEL_RAM: cpu.cpu_rdata = ram_rdata;
         SEL_SCR: cpu.cpu_rdata = scr_rdata;
         SEL_KBD: cpu.cpu_rdata = kbd_sync;
         default: cpu.cpu_rdata = 16'h0000;
      endcase
   end

   // Two-flop synchroniser for the asynchronous keyboard scan code.
   always_ff @(posedge clk) begin
      if (reset) begin
         kbd_meta <= 16'h0000;
         kbd_sync <= 16'h0000;
      end else begin
         kbd_meta <= kbd_code;
         kbd_sync <= kbd_meta;
      end
   end

   // Screen arbiter: video read, acknowledge, then a fixed CPU window before video may claim again.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         vid_ack_reg  <= 1'b0;
         vid_data_reg <= 16'h0000;
         win_cnt      <= 4'd0;
      end else begin
         vid_ack_reg <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (vid_req)
                  state <= ST_VID_RD;
            end
            ST_VID_RD: begin
               vid_ack_reg <= 1'b1;
               state       <= ST_VID_ACK;
            end
            ST_VID_ACK: begin
               vid_data_reg <= scr_rdata;
               win_cnt      <= WIN_LOAD;
               state        <= ST_CPU_WIN;
            end
            ST_CPU_WIN: begin
               if (win_cnt == 4'd0)
                  state <= ST_IDLE;
               else
                  win_cnt <= win_cnt - 4'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign vid_ack  = vid_ack_reg;
   // The video word arrives from the RAM in the ack cycle itself. It is held after that for late readers.
   assign vid_data = vid_ack_reg ? scr_rdata : vid_data_reg;

`ifdef HACK_MEM_BUS_ERR_EN
   logic bus_err_reg;

   // Sticky flag for CPU writes that have nowhere to go.
   always_ff @(posedge clk) begin
      if (reset)
         bus_err_reg <= 1'b0;
      else if (cpu.cpu_load && ((region == SEL_KBD) || (region == SEL_NONE)))
         bus_err_reg <= 1'b1;
   end

   assign bus_err = bus_err_reg;
`else
   assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_hack_mem_bus.sv
// Directed testbench for hack_mem_bus.
// The RAM and screen RAM are modelled here as synchronous-read arrays.
module tb_hack_mem_bus;

   logic        clk;
   logic        reset;
   logic [13:0] ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic [12:0] scr_addr;
   logic        scr_we;
   logic [15:0] scr_wdata;
   logic [15:0] scr_rdata;
   logic        vid_req;
   logic [12:0] vid_addr;
   logic        vid_ack;
   logic [15:0] vid_data;
   logic [15:0] kbd_code;
   logic        bus_err;

   int n_vec = 0;
   int n_bad = 0;

`ifdef HACK_MEM_BUS_ERR_EN
   localparam logic [15:0] ERR_EXP = 16'd1;
`else
   localparam logic [15:0] ERR_EXP = 16'd0;
`endif

   hack_mem_bus_if bus ();

   hack_mem_bus #(.CPU_WINDOW(4), .KBD_ADDR(16'h6000)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu       (bus),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .scr_addr  (scr_addr),
      .scr_we    (scr_we),
      .scr_wdata (scr_wdata),
      .scr_rdata (scr_rdata),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_ack   (vid_ack),
      .vid_data  (vid_data),
      .kbd_code  (kbd_code),
      .bus_err   (bus_err)
   );

   logic [15:0] ram_mem [16384];
   logic [15:0] scr_mem [8192];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: write on the clock edge and read the old contents with one cycle of latency.
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
      if (scr_we) scr_mem[scr_addr] <= scr_wdata;
      scr_rdata <= scr_mem[scr_addr];
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic half();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) ram_mem[i] = 16'h0000;
      for (int i = 0; i < 8192; i++)  scr_mem[i] = 16'h0000;
      ram_mem[16] = 16'hAAAA;
      scr_mem[5]  = 16'hBEEF;
      ram_rdata = 16'h0000;
      scr_rdata = 16'h0000;

      reset = 1'b1;
      vid_req = 1'b0;
      vid_addr = 13'd0;
      kbd_code = 16'h0000;
      bus.cpu_address = 16'h0010;
      bus.cpu_load = 1'b0;
      bus.cpu_wdata = 16'h0000;
      repeat (3) cyc();
      reset = 1'b0;

      // Reset state. rd_sel is unmapped, so the stale RAM word must not appear.
      half();
      chk("rst_rdata",   bus.cpu_rdata, 16'h0000);
      chk("rst_busy",    16'(bus.cpu_busy), 16'd0);
      chk("rst_ack",     16'(vid_ack), 16'd0);
      chk("rst_vdata",   vid_data, 16'h0000);
      chk("rst_err",     16'(bus_err), 16'd0);

      // RAM write and then read back.
      cyc();
      bus.cpu_address = 16'h0010;
      bus.cpu_wdata = 16'h1234;
      bus.cpu_load = 1'b1;
      half();
      chk("ram_we",      16'(ram_we), 16'd1);
      chk("ram_addr",    16'(ram_addr), 16'h0010);
      chk("ram_scr_we",  16'(scr_we), 16'd0);
      cyc();
      bus.cpu_load = 1'b0;
      cyc();
      half();
      chk("ram_rd",      bus.cpu_rdata, 16'h1234);

      // Keyboard read through the synchroniser.
      cyc();
      kbd_code = 16'h0041;
      bus.cpu_address = 16'h6000;
      cyc();
      half();
      chk("kbd_1cyc",    bus.cpu_rdata, 16'h0000);
      cyc();
      half();
      chk("kbd_2cyc",    bus.cpu_rdata, 16'h0041);

      // A keyboard write goes nowhere.
      cyc();
      bus.cpu_wdata = 16'hFFFF;
      bus.cpu_load = 1'b1;
      half();
      chk("kbdw_ram_we", 16'(ram_we), 16'd0);
      chk("kbdw_scr_we", 16'(scr_we), 16'd0);
      cyc();
      bus.cpu_load = 1'b0;
      half();
      chk("kbdw_err",    16'(bus_err), ERR_EXP);
      chk("kbdw_rd",     bus.cpu_rdata, 16'h0041);

      // Unmapped region: a read returns zero and a write is ignored.
      cyc();
      bus.cpu_address = 16'h7000;
      bus.cpu_load = 1'b1;
      half();
      chk("unm_ram_we",  16'(ram_we), 16'd0);
      chk("unm_scr_we",  16'(scr_we), 16'd0);
      cyc();
      bus.cpu_load = 1'b0;
      half();
      chk("unm_rd",      bus.cpu_rdata, 16'h0000);

      // Video fetch of screen word 5.
      cyc();
      bus.cpu_address = 16'h0010;
      vid_req = 1'b1;
      vid_addr = 13'd5;
      half();
      chk("vf_busy0",    16'(bus.cpu_busy), 16'd1);
      chk("vf_ack0",     16'(vid_ack), 16'd0);
      cyc();
      half();
      chk("vf_busy1",    16'(bus.cpu_busy), 16'd1);
      chk("vf_scr_addr", 16'(scr_addr), 16'd5);
      chk("vf_ack1",     16'(vid_ack), 16'd0);
      cyc();
      half();
      chk("vf_busy2",    16'(bus.cpu_busy), 16'd1);
      chk("vf_ack2",     16'(vid_ack), 16'd1);
      chk("vf_data",     vid_data, 16'hBEEF);
      cyc();
      vid_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         half();
         chk($sformatf("vf_win%0d_busy", i), 16'(bus.cpu_busy), 16'd0);
         chk($sformatf("vf_win%0d_ack", i), 16'(vid_ack), 16'd0);
         cyc();
      end
      half();
      chk("vf_hold",     vid_data, 16'hBEEF);

      // Tie: the video request and a CPU screen write arrive together. The video goes first.
      cyc();
      vid_req = 1'b1;
      vid_addr = 13'd5;
      bus.cpu_address = 16'h4000;
      bus.cpu_wdata = 16'h00FF;
      bus.cpu_load = 1'b1;
      half();
      chk("tie_busy",    16'(bus.cpu_busy), 16'd1);
      chk("tie_drop",    16'(scr_we), 16'd0);
      cyc();
      bus.cpu_load = 1'b0;
      cyc();
      half();
      chk("tie_ack",     16'(vid_ack), 16'd1);
      chk("tie_vdata",   vid_data, 16'hBEEF);
      cyc();
      vid_req = 1'b0;
      bus.cpu_load = 1'b1;
      half();
      chk("tie_wr_busy", 16'(bus.cpu_busy), 16'd0);
      chk("tie_wr_we",   16'(scr_we), 16'd1);
      chk("tie_wr_addr", 16'(scr_addr), 16'd0);
      cyc();
      bus.cpu_load = 1'b0;
      cyc();
      half();
      chk("tie_rd",      bus.cpu_rdata, 16'h00FF);
      repeat (4) cyc();

      // Starvation: vid_req is held high. The period is 3 busy cycles followed by 4 free cycles.
      // A RAM write is made in the middle of a busy cycle.
      bus.cpu_address = 16'h0020;
      bus.cpu_wdata = 16'h5A5A;
      vid_req = 1'b1;
      vid_addr = 13'd0;
      for (int k = 0; k < 21; k++) begin
         bus.cpu_load = (k == 1);
         half();
         chk($sformatf("sv%0d_busy", k), 16'(bus.cpu_busy), ((k % 7) < 3) ? 16'd1 : 16'd0);
         chk($sformatf("sv%0d_ack", k), 16'(vid_ack), ((k % 7) == 2) ? 16'd1 : 16'd0);
         if ((k % 7) == 2) chk($sformatf("sv%0d_vdata", k), vid_data, 16'h00FF);
         if (k == 1) chk("sv_ram_we", 16'(ram_we), 16'd1);
         cyc();
      end
      vid_req = 1'b0;
      bus.cpu_load = 1'b0;
      half();
      chk("sv_ram_rd",   bus.cpu_rdata, 16'h5A5A);

      // A reset in VID_RD aborts the read without an acknowledge.
      cyc();
      vid_req = 1'b1;
      vid_addr = 13'd5;
      cyc();
      half();
      chk("rr_busy",     16'(bus.cpu_busy), 16'd1);
      chk("rr_scr_addr", 16'(scr_addr), 16'd5);
      reset = 1'b1;
      vid_req = 1'b0;
      cyc();
      reset = 1'b0;
      half();
      chk("rr_ack0",     16'(vid_ack), 16'd0);
      chk("rr_busy0",    16'(bus.cpu_busy), 16'd0);
      chk("rr_vdata",    vid_data, 16'h0000);
      chk("rr_rdata",    bus.cpu_rdata, 16'h0000);
      chk("rr_err",      16'(bus_err), 16'd0);
      cyc();
      half();
      chk("rr_ack1",     16'(vid_ack), 16'd0);
      chk("rr_busy1",    16'(bus.cpu_busy), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Watchdog so that the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hack_mem_bus.md
Name: hack_mem_bus

Overview:
- Memory-side stage directly downstream of the Hack CPU core.
- Decodes the CPU's 16-bit data address into RAM, screen RAM and keyboard regions.
- Arbitrates screen RAM between the CPU and the video scan-out reader, and drives the CPU's busy/read-data handshake.
- Sits between the CPU, the external block RAMs (RAM, screen) and the keyboard/video front-ends.

Parameters:
- CPU_WINDOW, 4, cycles of guaranteed CPU screen access after each video word (anti-starvation); range 1..15.
- KBD_ADDR, 16'h6000, keyboard register address.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_address  in  16  CPU data address (A register)
- cpu_load  in  1  CPU write strobe, single cycle
- cpu_wdata  in  16  CPU write data
- cpu_rdata  out  16  read data to CPU
- cpu_busy  out  1  screen region currently owned or claimed by video
- ram_addr  out  14  data RAM address
- ram_we  out  1  data RAM write enable
- ram_wdata  out  16  data RAM write data
- ram_rdata  in  16  data RAM read data, 1-cycle synchronous latency
- scr_addr  out  13  screen RAM address
- scr_we  out  1  screen RAM write enable
- scr_wdata  out  16  screen RAM write data
- scr_rdata  in  16  screen RAM read data, 1-cycle latency
- vid_req  in  1  video wants a word; level, held until vid_ack
- vid_addr  in  13  video word address, stable while vid_req
- vid_ack  out  1  one-cycle pulse; vid_data valid this cycle
- vid_data  out  16  screen word for video
- kbd_code  in  16  asynchronous keyboard scan code
- bus_err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Region decode on cpu_address:
  - [14]=0 → RAM, ram_addr=[13:0].
  - [14:13]=10 → SCREEN, scr_addr=[12:0] when CPU owns.
  - ==KBD_ADDR → KBD.
  - Anything else → UNMAPPED.
- RAM path: ram_addr/ram_wdata combinational from CPU; ram_we=cpu_load & RAM. Never busy.
- Keyboard: kbd_code passes a 2-flop synchroniser; reset value 0. Writes to KBD are ignored.
- UNMAPPED: reads return 0; writes are ignored.
- Read data:
  - Region is registered every cycle into rd_sel.
  - cpu_rdata = mux(rd_sel): ram_rdata, scr_rdata, kbd_sync, or 0.
  - Read latency is 1 cycle from a stable address.
  - cpu_rdata returns 0 in the cycle after reset.
- Arbiter FSM states IDLE, VID_RD, VID_ACK, CPU_WIN:
  - IDLE: if vid_req → VID_RD (video wins any tie). cpu_busy=vid_req.
  - VID_RD: scr_addr=vid_addr, scr_we=0, cpu_busy=1 → VID_ACK.
  - VID_ACK: vid_data<=scr_rdata, vid_ack=1, cpu_busy=1; win_cnt<=CPU_WINDOW-1 → CPU_WIN.
  - CPU_WIN: vid_req ignored, cpu_busy=0. Decrement win_cnt; at 0 → IDLE.
- cpu_busy is combinational and asserted in any region. The CPU ignores it on its RAM/keyboard fast path.
- Screen writes: scr_we=cpu_load & SCREEN & !cpu_busy. A screen write attempted while busy is dropped; the CPU contract forbids this.
- Screen data: scr_wdata=cpu_wdata always. scr_addr follows the CPU except in VID_RD.
- Reset:
  - Values: state=IDLE, vid_ack=0, vid_data=0, win_cnt=0, rd_sel=UNMAPPED, kbd_sync=0, bus_err=0.
  - Reset mid-transaction aborts the video read without an ack; video re-requests.
- Back-to-back video requests are separated by exactly CPU_WINDOW non-busy cycles.

Optional Feature:
- Macro HACK_MEM_BUS_ERR_EN.
- Defined: bus_err sets on the cycle after cpu_load to KBD or UNMAPPED, and clears only on reset.
- Undefined: bus_err is tied 0 and no error logic is built.

Test Plan:
- RAM write/read:
  - Write cpu_address=0x0010, cpu_wdata=0x1234, cpu_load=1.
  - Then read 0x0010 → cpu_rdata=0x1234 one cycle later.
  - cpu_busy never affects RAM access.
- Keyboard:
  - kbd_code=0x0041 with address 0x6000 → cpu_rdata=0x0041 within 3 cycles.
  - Write to 0x6000 → no RAM/screen write. bus_err=1 with the macro, 0 without.
- Video fetch:
  - Screen word 0x0005 preloaded with 0xBEEF; vid_req=1, vid_addr=0x0005.
  - Expect cpu_busy=1 for 3 cycles, vid_ack pulse with vid_data=0xBEEF on cycle 3, then cpu_busy=0 for 4 cycles.
- Tie:
  - vid_req and CPU screen write to 0x4000 arrive in the same cycle.
  - Video is served first. The CPU write (0x00FF) lands once cpu_busy=0; a readback gives 0x00FF.
- Starvation: vid_req held high continuously → exactly 4 non-busy cycles between consecutive vid_ack pulses.
- Reset during VID_RD → no vid_ack; state IDLE and cpu_busy=0 the cycle after reset deasserts with vid_req=0.
